// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } state_e;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam logic [6:0]  GEN_CALL_ADDR = 7'h00;
    localparam int unsigned SYNC_STAGES   = 2;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes raw SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;

    // Idle bus level is high, so all flops reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    always_comb begin
        scl_s     = scl_sync_q[SYNC_STAGES-1];
        sda_s     = sda_sync_q[SYNC_STAGES-1];
        scl_rise  = scl_s & ~scl_hist_q;
        scl_fall  = ~scl_s & scl_hist_q;
        start_det = scl_s & sda_hist_q & ~sda_s;
        stop_det  = scl_s & ~sda_hist_q & sda_s;
    end

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: address match, ACK generation, byte delivery.
// Define I2C_GEN_CALL_EN to also accept the general-call address (7'h00, write).
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR  = 7'h50,
    parameter bit         RW_IGNORE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_rw,
    output logic       busy,
    output logic       stop_det
);

    logic scl_rise, scl_fall, sda_s, start_evt, stop_evt;

    i2c_bus_monitor u_bus_monitor (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_evt),
        .stop_det  (stop_evt)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_rw_q, rx_rw_d;
    logic       busy_q, busy_d;
    logic       stop_det_q, stop_det_d;
    logic [7:0] shifted;
    logic       last_bit, own_match, gen_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_rw_q    <= 1'b0;
            busy_q     <= 1'b0;
            stop_det_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            rx_rw_q    <= rx_rw_d;
            busy_q     <= busy_d;
            stop_det_q <= stop_det_d;
        end
    end

    always_comb begin
        shifted   = {shift_q[6:0], sda_s};
        last_bit  = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));
        own_match = (shifted[7:1] == OWN_ADDR) && (RW_IGNORE || !shifted[0]);
`ifdef I2C_GEN_CALL_EN
        gen_match = (shifted[7:1] == GEN_CALL_ADDR) && !shifted[0];
`else
        gen_match = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        rx_rw_d    = rx_rw_q;
        busy_d     = busy_q;
        stop_det_d = 1'b0;

        if (start_evt) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = StAddr;
        end else if (stop_evt) begin
            stop_det_d = 1'b1;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            state_d    = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: sda_oe_d = 1'b0;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        if (last_bit) begin
                            bit_cnt_d = 3'd0;
                            if (own_match || gen_match) begin
                                rx_rw_d = shifted[0];
                                busy_d  = 1'b1;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // First SCL fall starts the ACK drive, the second ends it.
                StAddrAck, StDataAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = StData;
                        end
                    end
                end
                StData: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        if (last_bit) begin
                            bit_cnt_d = 3'd0;
                            if (rx_ready) begin
                                rx_data_d  = shifted;
                                rx_valid_d = 1'b1;
                                state_d    = StDataAck;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = StIgnore;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_rw    = rx_rw_q;
    assign busy     = busy_q;
    assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx with a byte scoreboard and open-drain SDA model.
module tb_i2c_target_rx;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       rx_ready = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rw;
    logic       busy;
    logic       stop_det;

    // Wired-AND bus: the target pulls SDA low when sda_oe is set.
    assign sda_in = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_drv),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_rw    (rx_rw),
        .busy     (busy),
        .stop_det (stop_det)
    );

    int         n_pass = 0;
    int         n_chk = 0;
    int         oe_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (sda_oe) oe_cnt++;
        if (stop_det) stop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    tick(Q);
        scl_drv = 1'b1; tick(2 * Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        ack = sda_oe;   tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check({tag, " missing bytes"}, 0, exp_q.size());
                exp_q.delete();
            end else begin
                check({tag, " rx_data"}, got_q.pop_front(), exp_q.pop_front());
            end
        end
        check({tag, " extra rx_valid"}, got_q.size(), 0);
        got_q.delete();
    endtask

    initial begin
        logic ack;
        int   snap;
        logic [7:0] a0;
        a0 = 8'hA0;

        tick(3);
        check("reset sda_oe", sda_oe, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_rw", rx_rw, 0);
        check("reset busy", busy, 0);
        check("reset stop_det", stop_det, 0);
        reset = 1'b1;
        tick(4);

        // Single byte write
        snap = stop_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check("t1 addr ack", ack, 1);
        check("t1 busy", busy, 1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack); check("t1 data ack", ack, 1);
        i2c_stop();
        drain("t1");
        check("t1 rx_data hold", rx_data, 8'hA5);
        check("t1 stop_det", stop_cnt - snap, 1);
        check("t1 busy after stop", busy, 0);

        // Foreign address
        snap = oe_cnt;
        i2c_start();
        send_byte(8'hA2, ack); check("t2 addr nack", ack, 0);
        send_byte(8'h3C, ack); check("t2 data nack", ack, 0);
        check("t2 busy", busy, 0);
        i2c_stop();
        drain("t2");
        check("t2 sda_oe cycles", oe_cnt - snap, 0);

        // Multi-byte burst
        i2c_start();
        send_byte(8'hA0, ack); check("t3 addr ack", ack, 1);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), ack); check("t3 data ack", ack, 1);
        end
        i2c_stop();
        drain("t3");

        // Back-pressure NACK
        i2c_start();
        send_byte(8'hA0, ack); check("t4 addr ack", ack, 1);
        rx_ready = 1'b0;
        send_byte(8'hFF, ack); check("t4 nack", ack, 0);
        check("t4 busy", busy, 0);
        rx_ready = 1'b1;
        send_byte(8'h11, ack); check("t4 ignored ack", ack, 0);
        i2c_stop();
        drain("t4");

        // Partial byte cut by repeated START, then read-flagged address
        i2c_start();
        send_byte(8'hA0, ack); check("t5 addr ack", ack, 1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_start();
        send_byte(8'hA1, ack); check("t5 rs addr ack", ack, 1);
        check("t5 rx_rw", rx_rw, 1);
        check("t5 busy", busy, 1);
        i2c_stop();
        drain("t5");
        check("t5 busy after stop", busy, 0);

        // Asynchronous reset during an address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(a0[i]);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        check("t6 ack driven", sda_oe, 1);
        reset = 1'b0;
        #1;
        check("t6 async sda_oe", sda_oe, 0);
        check("t6 async busy", busy, 0);
        check("t6 async rx_rw", rx_rw, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        scl_drv = 1'b0; tick(Q);
        send_byte(8'hA0, ack); check("t6 no start ack", ack, 0);
        send_byte(8'h5A, ack); check("t6 no start data", ack, 0);
        check("t6 busy", busy, 0);
        i2c_stop();
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
